// File: rtl/store_commit_unit_if.sv
// Memory write-request bus between store_commit_unit (master) and data memory (slave).
// The request fields are held stable while valid is high and ready is low.
// The ack arrives after the request has been accepted.
`ifndef N
`define N 2
`endif
`ifndef ADDR
`define ADDR 32
`endif
`ifndef DATA
`define DATA 32
`endif

interface store_commit_unit_if #(
  parameter int ADDR_W = `ADDR,
  parameter int DATA_W = `DATA
);
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [3:0]        mem_req_be;
  logic              mem_req_ready;
  logic              mem_ack;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
    input  mem_req_ready, mem_ack
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
    output mem_req_ready, mem_ack
  );
endinterface

// File: rtl/store_commit_unit.sv
// store_commit_unit: drains retired stores from the store-queue head into a small
// circular buffer. It writes them to data memory one at a time (IDLE -> REQ -> WAIT).
// It also produces byte-lane aligned data and byte enables.
// Optional feature: define STORE_COMMIT_STATS_EN to add the 32-bit saturating
// stores_committed counter output.
`ifndef N
`define N 2
`endif
`ifndef ADDR
`define ADDR 32
`endif
`ifndef DATA
`define DATA 32
`endif

package store_commit_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [`ADDR-1:0] addr;
    logic [`DATA-1:0] data;
    mem_size_e        size;
  } STOREQ_ENTRY;
endpackage

module store_commit_unit
  import store_commit_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(`N+1)-1:0]    rob_retire_store_cnt,
  input  STOREQ_ENTRY [`N-1:0]       sq_head_entries,
  input  logic [`N-1:0]              sq_head_valids,
  output logic [$clog2(`N+1)-1:0]    sq_pop_cnt,
  output logic                       stall_retire,
  output logic                       buf_empty,
`ifdef STORE_COMMIT_STATS_EN
  output logic [31:0]                stores_committed,
`endif
  store_commit_unit_if.master        mem
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int RC_W  = $clog2(`N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  STOREQ_ENTRY      entry_q [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_next, free_slots;
  logic [1:0]       state_q;

  logic [`ADDR-1:0] req_addr_q;
  logic [`DATA-1:0] req_data_q;
  logic [3:0]       req_be_q;

  STOREQ_ENTRY      head_e;
  logic [3:0]       lane_be;
  logic [`DATA-1:0] lane_data;
  logic             pop;
  logic             bad_valid;

  // The head entry leaves the buffer only when its write is acknowledged.
  assign pop        = (state_q == WAIT) && mem.mem_ack;
  assign free_slots = CNT_W'(BUF_DEPTH) - count_q;
  assign count_next = count_q + CNT_W'(rob_retire_store_cnt) - CNT_W'(pop);

  assign sq_pop_cnt   = rob_retire_store_cnt;
  assign stall_retire = count_q > CNT_W'(BUF_DEPTH - `N);
  assign buf_empty    = (count_q == '0) && (state_q == IDLE);

  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_data  = req_data_q;
  assign mem.mem_req_be    = req_be_q;

  // Write the retired stores into consecutive slots starting at tail.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < `N; i++)
        if (RC_W'(i) < rob_retire_store_cnt)
          entry_q[tail_q + PTR_W'(i)] <= sq_head_entries[i];
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PTR_W'(rob_retire_store_cnt);
      if (pop) head_q <= head_q + PTR_W'(1);
      count_q <= count_next;
    end
  end

  // Align the head store's data and byte enables into its lane within the word.
  always_comb begin
    head_e    = entry_q[head_q];
    lane_be   = 4'hF;
    lane_data = head_e.data;
    case (head_e.size)
      BYTE: begin
        lane_be   = 4'b0001 << head_e.addr[1:0];
        lane_data = `DATA'(head_e.data[7:0]) << {head_e.addr[1:0], 3'b000};
      end
      HALF: begin
        lane_be   = head_e.addr[1] ? 4'b1100 : 4'b0011;
        lane_data = `DATA'(head_e.data[15:0]) << {head_e.addr[1], 4'b0000};
      end
      default: ;
    endcase
  end

  // Request FSM. The request registers load only in IDLE, so they stay frozen through REQ/WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_be_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (count_q != '0) begin
          state_q    <= REQ;
          req_addr_q <= head_e.addr & ~`ADDR'(3);
          req_data_q <= lane_data;
          req_be_q   <= lane_be;
        end
        REQ:  if (mem.mem_req_ready) state_q <= WAIT;
        WAIT: if (mem.mem_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STORE_COMMIT_STATS_EN
  // Count acknowledged writes, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset)
      stores_committed <= '0;
    else if (pop && stores_committed != 32'hFFFF_FFFF)
      stores_committed <= stores_committed + 32'd1;
  end
`endif

  // Flag any retired slot whose head-window valid bit is low.
  always_comb begin
    bad_valid = 1'b0;
    for (int i = 0; i < `N; i++)
      if (RC_W'(i) < rob_retire_store_cnt && !sq_head_valids[i]) bad_valid = 1'b1;
  end

  a_retire_fits:  assert property (@(posedge clock) disable iff (reset)
                    CNT_W'(rob_retire_store_cnt) <= free_slots);
  a_retire_valid: assert property (@(posedge clock) disable iff (reset) !bad_valid);
  a_no_stalled:   assert property (@(posedge clock) disable iff (reset)
                    !(stall_retire && rob_retire_store_cnt != '0));

endmodule

// File: tb/tb_store_commit_unit.sv
// Directed self-checking bench for store_commit_unit (N=2, BUF_DEPTH=4, 32-bit addr/data).
`ifndef N
`define N 2
`endif
`ifndef ADDR
`define ADDR 32
`endif
`ifndef DATA
`define DATA 32
`endif

module tb_store_commit_unit;
  import store_commit_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [$clog2(`N+1)-1:0] rob_retire_store_cnt = '0;
  STOREQ_ENTRY [`N-1:0]    sq_head_entries = '0;
  logic [`N-1:0]           sq_head_valids = '0;
  logic [$clog2(`N+1)-1:0] sq_pop_cnt;
  logic                    stall_retire;
  logic                    buf_empty;
`ifdef STORE_COMMIT_STATS_EN
  logic [31:0]             stores_committed;
`endif

  int n_cmp = 0;
  int n_err = 0;

  store_commit_unit_if mem_if ();

  store_commit_unit #(.BUF_DEPTH(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .rob_retire_store_cnt (rob_retire_store_cnt),
    .sq_head_entries      (sq_head_entries),
    .sq_head_valids       (sq_head_valids),
    .sq_pop_cnt           (sq_pop_cnt),
    .stall_retire         (stall_retire),
    .buf_empty            (buf_empty),
`ifdef STORE_COMMIT_STATS_EN
    .stores_committed     (stores_committed),
`endif
    .mem                  (mem_if)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic STOREQ_ENTRY mk(input logic [31:0] a, input logic [31:0] d, input mem_size_e s);
    STOREQ_ENTRY e;
    e.addr = a;
    e.data = d;
    e.size = s;
    return e;
  endfunction

  // Present cnt stores for one cycle; returns at the sample point of the next cycle.
  task automatic retire(input int cnt, input STOREQ_ENTRY e0, input STOREQ_ENTRY e1);
    rob_retire_store_cnt = cnt[1:0];
    sq_head_entries[0]   = e0;
    sq_head_entries[1]   = e1;
    sq_head_valids       = (cnt == 2) ? 2'b11 : (cnt == 1) ? 2'b01 : 2'b00;
    #1;
    chk("pop_cnt", 64'(sq_pop_cnt), 64'(cnt));
    step();
    rob_retire_store_cnt = '0;
    sq_head_valids       = '0;
  endtask

  // Wait (bounded) for a request, check it, accept it, then ack one cycle later.
  task automatic drain_one(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    int k = 0;
    while (!mem_if.mem_req_valid && k < 30) begin
      step();
      k++;
    end
    chk({tag, ".vld"},  64'(mem_if.mem_req_valid), 64'd1);
    chk({tag, ".addr"}, 64'(mem_if.mem_req_addr),  64'(a));
    chk({tag, ".be"},   64'(mem_if.mem_req_be),    64'(be));
    chk({tag, ".data"}, 64'(mem_if.mem_req_data),  64'(d));
    mem_if.mem_req_ready = 1'b1;
    step();
    mem_if.mem_req_ready = 1'b0;
    chk({tag, ".wait_vld"}, 64'(mem_if.mem_req_valid), 64'd0);
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0;
  endtask

  initial begin
    STOREQ_ENTRY z;
    int nret;
    z = '0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_ack       = 1'b0;

    // reset then idle
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("rst.buf_empty", 64'(buf_empty), 64'd1);
    chk("rst.vld",       64'(mem_if.mem_req_valid), 64'd0);
    chk("rst.stall",     64'(stall_retire), 64'd0);
    chk("rst.pop_cnt",   64'(sq_pop_cnt), 64'd0);
    chk("rst.addr",      64'(mem_if.mem_req_addr), 64'd0);
    chk("rst.be",        64'(mem_if.mem_req_be), 64'd0);

    // single byte store: t+1 buffered, t+2 request
    retire(1, mk(32'h1003, 32'h0000_00AB, BYTE), z);
    chk("b1.t1_vld",   64'(mem_if.mem_req_valid), 64'd0);
    chk("b1.t1_empty", 64'(buf_empty), 64'd0);
    step();
    chk("b1.t2_vld",   64'(mem_if.mem_req_valid), 64'd1);
    drain_one("b1", 32'h1000, 4'b1000, 32'hAB00_0000);
    chk("b1.empty_after", 64'(buf_empty), 64'd1);

    // half then word, in order
    retire(2, mk(32'h2002, 32'h0000_1234, HALF), mk(32'h3000, 32'hDEAD_BEEF, WORD));
    drain_one("hw0", 32'h2000, 4'b1100, 32'h1234_0000);
    drain_one("hw1", 32'h3000, 4'hF,    32'hDEAD_BEEF);

    // backpressure: fill until stall, hold ready low, then drain
    nret = 0;
    for (int k = 0; k < 4; k++) begin
      if (!stall_retire)
        retire(2, mk(32'h4000 + 32'(8*k), 32'h4000_0000 + 32'(2*k), WORD),
                  mk(32'h4004 + 32'(8*k), 32'h4000_0001 + 32'(2*k), WORD));
      if (!stall_retire) nret += 2;
      else if (nret < 4) nret += 2;
    end
    chk("bp.stall", 64'(stall_retire), 64'd1);
    chk("bp.nret",  64'(nret), 64'd4);
    for (int k = 0; k < 10; k++) begin
      chk("bp.hold_vld",   64'(mem_if.mem_req_valid), 64'd1);
      chk("bp.hold_addr",  64'(mem_if.mem_req_addr),  64'h4000);
      chk("bp.hold_data",  64'(mem_if.mem_req_data),  64'h4000_0000);
      chk("bp.hold_stall", 64'(stall_retire), 64'd1);
      step();
    end
    drain_one("bp0", 32'h4000, 4'hF, 32'h4000_0000);
    drain_one("bp1", 32'h4004, 4'hF, 32'h4000_0001);
    drain_one("bp2", 32'h4008, 4'hF, 32'h4000_0002);
    drain_one("bp3", 32'h400C, 4'hF, 32'h4000_0003);
    chk("bp.empty", 64'(buf_empty), 64'd1);
    chk("bp.stall_clr", 64'(stall_retire), 64'd0);

    // wrap-around: enqueue 3, drain 3, enqueue 4
    retire(2, mk(32'h5001, 32'h0000_005A, BYTE), mk(32'h5003, 32'h1111_CAFE, HALF));
    retire(1, mk(32'h5000, 32'hFFFF_FF12, BYTE), z);
    drain_one("w0", 32'h5000, 4'b0010, 32'h0000_5A00);
    drain_one("w1", 32'h5000, 4'b1100, 32'hCAFE_0000);
    drain_one("w2", 32'h5000, 4'b0001, 32'h0000_0012);
    retire(2, mk(32'h6007, 32'h0102_0304, WORD), mk(32'h6002, 32'h0000_0077, BYTE));
    chk("w.stall_mid", 64'(stall_retire), 64'd0);
    retire(2, mk(32'h6000, 32'h0000_BEEF, HALF), mk(32'h6008, 32'hA5A5_A5A5, WORD));
    chk("w.stall_full", 64'(stall_retire), 64'd1);
    drain_one("w3", 32'h6004, 4'hF,    32'h0102_0304);
    drain_one("w4", 32'h6000, 4'b0100, 32'h0077_0000);
    drain_one("w5", 32'h6000, 4'b0011, 32'h0000_BEEF);
    drain_one("w6", 32'h6008, 4'hF,    32'hA5A5_A5A5);
    chk("w.empty", 64'(buf_empty), 64'd1);
`ifdef STORE_COMMIT_STATS_EN
    chk("stats.count", 64'(stores_committed), 64'd14);
`endif

    // reset while in WAIT with two buffered stores
    retire(2, mk(32'h7000, 32'h1, WORD), mk(32'h7004, 32'h2, WORD));
    for (int k = 0; k < 30 && !mem_if.mem_req_valid; k++) step();
    chk("rw.vld", 64'(mem_if.mem_req_valid), 64'd1);
    mem_if.mem_req_ready = 1'b1;
    step();
    mem_if.mem_req_ready = 1'b0;
    chk("rw.in_wait", 64'(mem_if.mem_req_valid), 64'd0);
    chk("rw.busy",    64'(buf_empty), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw.vld0",  64'(mem_if.mem_req_valid), 64'd0);
    chk("rw.empty", 64'(buf_empty), 64'd1);
    chk("rw.addr0", 64'(mem_if.mem_req_addr), 64'd0);
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0;
    step();
    chk("rw.late_empty", 64'(buf_empty), 64'd1);
    chk("rw.late_vld",   64'(mem_if.mem_req_valid), 64'd0);
    chk("rw.late_stall", 64'(stall_retire), 64'd0);
`ifdef STORE_COMMIT_STATS_EN
    chk("rw.stats", 64'(stores_committed), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
